// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix: decodes the PS/2 scan-code byte stream (E0/F0/E1 prefixes),
// translates codes through a run-time loadable map RAM and maintains an
// active-low ROWS x COLS key matrix. The matrix is read combinationally
// through row_n.
// Map RAM has no reset and is meant to be loaded by software before use;
// FPGA bitstreams zero it at configuration, which leaves every entry invalid.
module ps2_key_matrix #(
  parameter  int ROWS        = 12,
  parameter  int COLS        = 7,
  parameter  int SHIFT_ROW   = 0,
  parameter  int SHIFT_COL   = 6,
  parameter  int RESET_PULSE = 1024,
  localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int EW          = 4 + RW + CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      kdata,
  input  logic            valid,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] KD,
  input  logic            map_we,
  input  logic [8:0]      map_addr,
  input  logic [EW-1:0]   map_wdata,
  input  logic            clear_all,
  output logic            reset_key,
  output logic            overrun
);

  localparam int CELLS = ROWS * COLS;
  localparam int FW    = $clog2(CELLS + 1);
  localparam int PW    = $clog2(RESET_PULSE + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_REL     = 3'd2;
  localparam logic [2:0] S_EXT_REL = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [2:0]                 skip_q, skip_d;
  logic [PW-1:0]              pcnt_q, pcnt_d;
  logic [ROWS-1:0][COLS-1:0]  km_q, km_d;
  logic [FW-1:0]              fcnt_q, fcnt_d;
  logic                       rheld_q, rheld_d;
  logic                       ovr_q, ovr_d;
  logic                       lk_vld_q, lk_vld_d;
  logic                       lk_brk_q, lk_brk_d;
  logic [8:0]                 lk_addr_d;
  logic                       pload;
  logic                       is_ovr;
  logic                       wipe;

  logic [EW-1:0]              map_mem [512];
  logic [EW-1:0]              rd_q;

  // Map entry fields as seen by the apply stage.
  logic          e_valid, e_reset, e_force, unused_spare;
  logic [RW-1:0] e_row;
  logic [CW-1:0] e_col;
  logic          pressed;

  assign e_valid      = rd_q[EW-1];
  assign e_reset      = rd_q[EW-2];
  assign e_force      = rd_q[EW-3];
  assign unused_spare = rd_q[EW-4];
  assign e_row        = rd_q[CW+RW-1:CW];
  assign e_col        = rd_q[CW-1:0];

  // 00/FF from the PS/2 receiver means it lost sync; Pause bytes are only counted.
  assign is_ovr = valid && (kdata == 8'h00 || kdata == 8'hFF) && (state_q != S_PAUSE);
  assign wipe   = is_ovr || clear_all;

  // Prefix decoder: tracks E0/F0/E1 and issues one lookup per complete code.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    lk_vld_d  = 1'b0;
    lk_brk_d  = 1'b0;
    lk_addr_d = {1'b0, kdata};
    ovr_d     = 1'b0;
    pload     = 1'b0;
    if (valid) begin
      case (state_q)
        S_IDLE: begin
          if (kdata == 8'hE0)      state_d = S_EXT;
          else if (kdata == 8'hF0) state_d = S_REL;
          else if (kdata == 8'hE1) begin
            state_d = S_PAUSE;
            skip_d  = 3'd7;
          end else lk_vld_d = 1'b1;
        end
        S_EXT: begin
          if (kdata == 8'hF0) state_d = S_EXT_REL;
          else begin
            lk_vld_d  = 1'b1;
            lk_addr_d = {1'b1, kdata};
            state_d   = S_IDLE;
          end
        end
        S_REL: begin
          lk_vld_d = 1'b1;
          lk_brk_d = 1'b1;
          state_d  = S_IDLE;
        end
        S_EXT_REL: begin
          lk_vld_d  = 1'b1;
          lk_brk_d  = 1'b1;
          lk_addr_d = {1'b1, kdata};
          state_d   = S_IDLE;
        end
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = S_IDLE;
            pload   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (is_ovr) ovr_d = 1'b1;
    // A wipe drops both the code being issued now and any partial prefix.
    if (wipe) begin
      state_d  = S_IDLE;
      lk_vld_d = 1'b0;
    end
  end

  // Pause pulse counter: loaded at the end of an E1 sequence, runs down to zero.
  always_comb begin
    pcnt_d = pcnt_q;
    if (pload)              pcnt_d = PW'(RESET_PULSE);
    else if (pcnt_q != '0)  pcnt_d = pcnt_q - PW'(1);
  end

  // Apply stage: update the addressed cell, force-shift count and reset flag.
  always_comb begin
    km_d    = km_q;
    fcnt_d  = fcnt_q;
    rheld_d = rheld_q;
    pressed = 1'b0;
    if (lk_vld_q && e_valid && (int'(e_row) < ROWS) && (int'(e_col) < COLS)) begin
      pressed = ~km_q[e_row][e_col];
      if (!lk_brk_q) begin
        km_d[e_row][e_col] = 1'b0;
        // Only a fresh press counts; typematic repeats find the cell already down.
        if (e_force && !pressed && fcnt_q != FW'(CELLS)) fcnt_d = fcnt_q + FW'(1);
        if (e_reset) rheld_d = 1'b1;
      end else begin
        km_d[e_row][e_col] = 1'b1;
        if (e_force && pressed && fcnt_q != '0) fcnt_d = fcnt_q - FW'(1);
        if (e_reset) rheld_d = 1'b0;
      end
    end
    // Wipe overrides an apply landing in the same cycle.
    if (wipe) begin
      km_d    = '1;
      fcnt_d  = '0;
      rheld_d = 1'b0;
    end
  end

  // Map RAM: one write port, registered read; read-before-write on collision.
  always_ff @(posedge clk) begin
    if (map_we) map_mem[map_addr] <= map_wdata;
    rd_q <= map_mem[lk_addr_d];
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      skip_q   <= '0;
      pcnt_q   <= '0;
      km_q     <= '1;
      fcnt_q   <= '0;
      rheld_q  <= 1'b0;
      ovr_q    <= 1'b0;
      lk_vld_q <= 1'b0;
      lk_brk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      pcnt_q   <= pcnt_d;
      km_q     <= km_d;
      fcnt_q   <= fcnt_d;
      rheld_q  <= rheld_d;
      ovr_q    <= ovr_d;
      lk_vld_q <= lk_vld_d;
      lk_brk_q <= lk_brk_d;
    end
  end

  // Column readout: forced shift merged into the shift cell, AND over selected rows.
  always_comb begin
    logic [ROWS-1:0][COLS-1:0] km_eff;
    km_eff = km_q;
    km_eff[SHIFT_ROW][SHIFT_COL] = km_q[SHIFT_ROW][SHIFT_COL] & (fcnt_q == '0);
    KD = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_n[r]) KD = KD & km_eff[r];
    end
  end

  assign reset_key = rheld_q | (pcnt_q != '0);
  assign overrun   = ovr_q;

endmodule
